// File: rtl/icp_mem.sv
// Multi-port 64-bit word memory for the intcode core: zero-latency core reads,
// edge-committed writes, an idle-time host port and an optional post-reset clear.

module icp_mem_port #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              run,
  output logic              rd,
  output logic              wr,
  output logic              busy,
  output logic              err
);
  logic in_range;

  assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign busy     = (op == 2'd1) || (op == 2'd2);
  assign rd       = run && (op == 2'd1) && in_range;
  assign wr       = run && (op == 2'd2) && in_range;
  // op 3 is a no-op that still flags a bad request
  assign err      = run && ((busy && !in_range) || (op == 2'd3));
endmodule

module icp_mem #(
  parameter int DEPTH          = 8192,
  parameter int ADDR_W         = 13,
  parameter int DATA_W         = 64,
  parameter int NUM_PORTS      = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_PORTS-1:0][1:0]         i_op,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  i_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  i_data,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  o_data,
  input  logic                              i_host_valid,
  input  logic                              i_host_we,
  input  logic [ADDR_W-1:0]                 i_host_addr,
  input  logic [DATA_W-1:0]                 i_host_wdata,
  output logic                              o_host_ready,
  output logic                              o_host_rvalid,
  output logic [DATA_W-1:0]                 o_host_rdata,
  output logic                              o_mem_ready,
  output logic                              o_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                state, state_nx;
  logic [ADDR_W-1:0]     clr_cnt;
  logic                  run, clr_we, clr_last;
  logic [NUM_PORTS-1:0]  rd, wr, busy, perr;
  logic                  host_in, host_xfer;
  logic [DATA_W-1:0]     mem [DEPTH];

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      icp_mem_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_port (
        .op   (i_op[p]),
        .addr (i_addr[p]),
        .run  (run),
        .rd   (rd[p]),
        .wr   (wr[p]),
        .busy (busy[p]),
        .err  (perr[p])
      );
      assign o_data[p] = rd[p] ? mem[i_addr[p][AW-1:0]] : '0;
    end
  endgenerate

  assign host_in   = {1'b0, i_host_addr} < (ADDR_W+1)'(DEPTH);
  assign host_xfer = i_host_valid && o_host_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr_last) state_nx = S_RUN;
  end

  always_comb begin
    run          = (state == S_RUN);
    clr_we       = (state == S_CLEAR);
    clr_last     = clr_we && (clr_cnt == ADDR_W'(DEPTH-1));
    // core owns the array whenever any port has a real access pending
    o_host_ready = run && !(|busy);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_cnt       <= '0;
      o_mem_ready   <= 1'b0;
      o_host_rvalid <= 1'b0;
      o_host_rdata  <= '0;
      o_err         <= 1'b0;
    end else begin
      if (clr_we) clr_cnt <= clr_cnt + ADDR_W'(1);
      o_mem_ready   <= (state_nx == S_RUN);
      o_host_rvalid <= host_xfer && !i_host_we;
      if (host_xfer && !i_host_we)
        o_host_rdata <= host_in ? mem[i_host_addr[AW-1:0]] : '0;
      if ((|perr) || (host_xfer && !host_in)) o_err <= 1'b1;
    end
  end

  // descending loop so the lowest-indexed port's write lands last and wins
  always_ff @(posedge i_clk) begin
    if (clr_we) mem[clr_cnt[AW-1:0]] <= '0;
    if (host_xfer && i_host_we && host_in) mem[i_host_addr[AW-1:0]] <= i_host_wdata;
    for (int q = NUM_PORTS-1; q >= 0; q--)
      if (wr[q]) mem[i_addr[q][AW-1:0]] <= i_data[q];
  end
endmodule

// File: tb/tb_icp_mem.sv
// Directed bench for icp_mem: a full-size instance checked every cycle against a
// word-level model, plus a half-depth instance for out-of-range behaviour.

module tb_icp_mem;
  localparam int NP = 4, AW = 13, DW = 64, DEPTH = 8192, DEPTH_B = 4096;

  logic clk = 1'b0, rst = 1'b1;
  logic [NP-1:0][1:0]    op;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][DW-1:0] data;
  logic [NP-1:0][DW-1:0] a_data, b_data;
  logic          hv, hwe;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          a_hready, a_rvalid, a_ready, a_err;
  logic          b_hready, b_rvalid, b_ready, b_err;
  logic [DW-1:0] a_hrdata, b_hrdata;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  icp_mem u_dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_addr(addr), .i_data(data), .o_data(a_data),
    .i_host_valid(hv), .i_host_we(hwe), .i_host_addr(haddr), .i_host_wdata(hwdata),
    .o_host_ready(a_hready), .o_host_rvalid(a_rvalid), .o_host_rdata(a_hrdata),
    .o_mem_ready(a_ready), .o_err(a_err)
  );

  icp_mem #(.DEPTH(DEPTH_B)) u_small (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_addr(addr), .i_data(data), .o_data(b_data),
    .i_host_valid(hv), .i_host_we(hwe), .i_host_addr(haddr), .i_host_wdata(hwdata),
    .o_host_ready(b_hready), .o_host_rvalid(b_rvalid), .o_host_rdata(b_hrdata),
    .o_mem_ready(b_ready), .o_err(b_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // word-level model of the full-size instance; unwritten words read as zero after clear
  logic [63:0] mm [int];
  int          m_cnt = 0;
  bit          m_ready = 0, m_err = 0, m_rvalid = 0;
  logic [63:0] m_rdata = 64'd0;

  function automatic logic [63:0] mrd(input int a);
    return mm.exists(a) ? mm[a] : 64'd0;
  endfunction

  function automatic bit core_busy();
    for (int p = 0; p < NP; p++) if (op[p] == 2'd1 || op[p] == 2'd2) return 1'b1;
    return 1'b0;
  endfunction

  // inputs only move just after posedge, so at negedge they are what the next edge samples
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_cnt = 0; m_ready = 0; m_err = 0; m_rvalid = 0; m_rdata = 64'd0;
    end
    chk("mem_ready", 64'(a_ready), 64'(m_ready));
    chk("err", 64'(a_err), 64'(m_err));
    chk("host_rvalid", 64'(a_rvalid), 64'(m_rvalid));
    chk("host_rdata", a_hrdata, m_rdata);
    chk("host_ready", 64'(a_hready), 64'(m_ready && !core_busy()));
    for (int p = 0; p < NP; p++)
      chk($sformatf("o_data[%0d]", p), a_data[p],
          (m_ready && op[p] == 2'd1 && int'(addr[p]) < DEPTH) ? mrd(int'(addr[p])) : 64'd0);
    if (!rst) begin
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == DEPTH) begin m_ready = 1; mm.delete(); end
      end else begin
        m_rvalid = 0;
        for (int p = NP-1; p >= 0; p--) begin
          if (op[p] == 2'd3) m_err = 1;
          if (op[p] == 2'd1 || op[p] == 2'd2) begin
            if (int'(addr[p]) >= DEPTH) m_err = 1;
            else if (op[p] == 2'd2) mm[int'(addr[p])] = data[p];
          end
        end
        if (hv && !core_busy()) begin
          if (int'(haddr) >= DEPTH) begin
            m_err = 1;
            if (!hwe) begin m_rvalid = 1; m_rdata = 64'd0; end
          end else if (hwe) mm[int'(haddr)] = hwdata;
          else begin m_rvalid = 1; m_rdata = mrd(int'(haddr)); end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0, nb = -1;
    while (!a_ready && n < 10000) begin
      tick(); n++;
      if (b_ready && nb < 0) nb = n;
    end
    chk({name, " clear cycles"}, 64'(n), 64'(DEPTH));
    chk({name, " small clear cycles"}, 64'(nb), 64'(DEPTH_B));
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hv = 1'b1; hwe = 1'b1; haddr = a; hwdata = d;
    tick();
    hv = 1'b0; hwe = 1'b0;
  endtask

  task automatic host_rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    hv = 1'b1; hwe = 1'b0; haddr = a;
    tick();
    hv = 1'b0;
    chk({name, " rvalid"}, 64'(a_rvalid), 64'd1);
    chk({name, " rdata"}, a_hrdata, exp);
    tick();
    chk({name, " rvalid drop"}, 64'(a_rvalid), 64'd0);
  endtask

  initial begin
    op = '0; addr = '0; data = '0; hv = 1'b0; hwe = 1'b0; haddr = '0; hwdata = '0;
    repeat (3) tick();
    chk("reset mem_ready", 64'(a_ready), 64'd0);
    chk("reset rdata", a_hrdata, 64'd0);
    rst = 1'b0;
    wait_ready("first");

    host_rd("top word", 13'h1FFF, 64'd0);
    chk("small oor host read err", 64'(b_err), 64'd1);
    chk("small oor host rdata", b_hrdata, 64'd0);

    host_wr(13'd0, 64'd1); host_wr(13'd1, 64'd9); host_wr(13'd2, 64'd10); host_wr(13'd3, 64'd3);
    for (int p = 0; p < NP; p++) begin op[p] = 2'd1; addr[p] = AW'(p); end
    #1;
    chk("core rd0", a_data[0], 64'd1);
    chk("core rd1", a_data[1], 64'd9);
    chk("core rd2", a_data[2], 64'd10);
    chk("core rd3", a_data[3], 64'd3);
    tick();
    op = '0;
    host_rd("host rd2", 13'd2, 64'd10);

    host_wr(13'd5, 64'h55);
    op[0] = 2'd2; addr[0] = 13'd5; data[0] = 64'hAA;
    op[1] = 2'd1; addr[1] = 13'd5;
    op[2] = 2'd2; addr[2] = 13'd5; data[2] = 64'hBB;
    #1;
    chk("rdw old value", a_data[1], 64'h55);
    tick();
    op = '0;
    host_rd("collision", 13'd5, 64'hAA);

    for (int p = 0; p < NP; p++) begin op[p] = 2'd2; addr[p] = AW'(20 + p); data[p] = 64'(100 + p); end
    tick();
    op = '0;
    host_rd("distinct wr", 13'd23, 64'd103);

    op[3] = 2'd1; addr[3] = 13'd1;
    hv = 1'b1; hwe = 1'b0; haddr = 13'd2;
    #1;
    chk("blocked ready", 64'(a_hready), 64'd0);
    tick(); chk("blocked rvalid a", 64'(a_rvalid), 64'd0);
    tick(); chk("blocked rvalid b", 64'(a_rvalid), 64'd0);
    op = '0;
    #1;
    chk("unblocked ready", 64'(a_hready), 64'd1);
    tick();
    hv = 1'b0;
    chk("unblocked rvalid", 64'(a_rvalid), 64'd1);
    chk("unblocked rdata", a_hrdata, 64'd10);
    tick();
    chk("unblocked rvalid drop", 64'(a_rvalid), 64'd0);

    rst = 1'b1; tick(); rst = 1'b0;
    repeat (100) tick();
    chk("midclear ready", 64'(a_ready), 64'd0);
    rst = 1'b1; tick();
    chk("midclear reset ready", 64'(a_ready), 64'd0);
    rst = 1'b0;
    wait_ready("restart");
    chk("post reset err", 64'(a_err), 64'd0);
    chk("post reset small err", 64'(b_err), 64'd0);

    host_wr(13'd0, 64'h77);
    op[1] = 2'd2; addr[1] = 13'h1000; data[1] = 64'hDEAD;
    tick();
    op = '0;
    chk("oor wr small err", 64'(b_err), 64'd1);
    chk("in range wr no err", 64'(a_err), 64'd0);
    host_rd("word0", 13'd0, 64'h77);
    chk("small word0 intact", b_hrdata, 64'h77);
    host_rd("word1000", 13'h1000, 64'hDEAD);
    chk("small oor rd zero", b_hrdata, 64'd0);
    tick();
    chk("small err sticky", 64'(b_err), 64'd1);

    op[0] = 2'd3;
    #1;
    chk("op3 host ready", 64'(a_hready), 64'd1);
    tick();
    op = '0;
    chk("op3 err", 64'(a_err), 64'd1);
    repeat (2) tick();
    chk("op3 err sticky", 64'(a_err), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icp_mem.md
Name: icp_mem

Overview:
- Multi-port 64-bit word memory that responds to the intcode processor's four memory ports.
- Accepts ops NONE=0, READ=1 and WRITE=2 on each port.
- Reads are zero-latency: data is valid in the same cycle the op and address are presented. Writes commit at the clock edge.
- A host port loads programs and dumps results while the core is idle.
- An optional post-reset clear sequencer zeroes the whole array before service begins.

Parameters:
- DEPTH, 8192, number of 64-bit words implemented (must be ≤ 2^ADDR_W).
- ADDR_W, 13, address width of core and host ports.
- DATA_W, 64, word width.
- NUM_PORTS, 4, number of core ports.
- CLEAR_ON_RESET, 1, when 1, zero all words after reset before serving.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_op[NUM_PORTS-1:0]  in  2 each  per-port op: 0 NONE, 1 READ, 2 WRITE, 3 reserved.
- i_addr[NUM_PORTS-1:0]  in  ADDR_W each  per-port word address.
- i_data[NUM_PORTS-1:0]  in  DATA_W each  per-port write data.
- o_data[NUM_PORTS-1:0]  out  DATA_W each  per-port read data (combinational).
- i_host_valid  in  1  host request valid.
- i_host_we  in  1  host request is a write (1) or read (0).
- i_host_addr  in  ADDR_W  host word address.
- i_host_wdata  in  DATA_W  host write data.
- o_host_ready  out  1  host request accepted this cycle.
- o_host_rvalid  out  1  one-cycle pulse: o_host_rdata valid.
- o_host_rdata  out  DATA_W  host read data (registered).
- o_mem_ready  out  1  clear complete; serving requests.
- o_err  out  1  sticky error flag.

Behaviour:
- Reset (async, i_rst=1):
  - Outputs: o_mem_ready=0, o_host_rvalid=0, o_host_rdata=0, o_err=0. Clear counter=0.
  - State goes to S_CLEAR if CLEAR_ON_RESET=1, else S_RUN.
  - Array contents are not reset asynchronously.
  - Reset asserted mid-clear restarts the clear from address 0.
- State S_CLEAR:
  - Each cycle, write 0 to mem[counter], then counter++.
  - After writing DEPTH-1 (DEPTH cycles total), go to S_RUN and set o_mem_ready=1 on that same edge.
  - While in S_CLEAR: core ops are ignored (o_data=0, writes dropped, no error) and o_host_ready=0.
- State S_RUN (terminal until reset):
- Core read:
  - o_data[p] = mem[i_addr[p]] when i_op[p]==READ and the address is in range; otherwise 0.
  - Purely combinational, zero-cycle latency.
- Core write:
  - When i_op[p]==WRITE and the address is in range, mem[i_addr[p]] <= i_data[p] at the edge.
  - Multiple ports writing the same address in one cycle: the lowest port index wins. Writes to distinct addresses all commit.
- Read-during-write to the same address in one cycle: the read returns the pre-edge (old) value.
- Out-of-range address (addr ≥ DEPTH) with op READ or WRITE:
  - Read returns 0; write is dropped.
  - o_err is set on the next edge and stays set until reset.
- Op 3: treated as NONE and sets o_err.
- Host port:
  - o_host_ready = (state==S_RUN) && no core port has op READ or WRITE. Combinational; does not depend on i_host_valid.
  - A transfer occurs on an edge where i_host_valid && o_host_ready.
  - Host write: mem[i_host_addr] <= i_host_wdata.
  - Host read: o_host_rdata <= mem[i_host_addr] and o_host_rvalid=1 on that edge. o_host_rvalid drops the following cycle unless another read is accepted.
  - o_host_rdata holds its value between reads.
  - Host out-of-range: a write is dropped; a read returns 0 with rvalid=1. Both set o_err.
- Core always has priority: a host request stays pending, with no side effects, while any core op is active.

Test Plan:
- Clear sequence: reset, then poll → o_mem_ready rises exactly 8192 cycles after reset deassertion; a host read of 0x1FFF returns 0.
- Program load and core read:
  - Host writes 1, 9, 10, 3 to addresses 0..3.
  - Core READs ports 0..3 at addresses 0..3 in one cycle → o_data = 1, 9, 10, 3 in that cycle.
  - Host read of address 2 → rdata=10 with a one-cycle rvalid.
- Write collision: ports 0 and 2 both WRITE address 0x0005 with 0xAA and 0xBB → host readback gives 0xAA. In the same cycle, port 1 READ of 0x0005 returns the old value.
- Host blocked by core: host read asserted while port 3 READs → o_host_ready=0 until the core ops return to NONE; then the transfer completes with rvalid one cycle later.
- Error paths (DEPTH=4096):
  - Port 1 WRITE to 0x1000 → array unchanged, o_err=1 sticky.
  - Op 3 after reset also sets o_err.
- Reset mid-clear: assert i_rst at clear count 100 → o_mem_ready stays 0, and the clear takes a full 8192 cycles after release.
